multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles a memory access waits for mem_ready before the FSM faults.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode from instruction register bits [31:26].
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 mem_req, mem_we, iord  output  1 each  memory request, write enable, data/instruction address select.
REQ-007 ir_write, pc_write, pc_write_cond  output  1 each  IR load, unconditional PC load, branch-conditional PC load.
REQ-008 reg_write, reg_dst, mem_to_reg  output  1 each  register-file write, rd/rt select, memory/ALU writeback select.
REQ-009 alu_src_a  output  1;  alu_src_b  output  2;  alu_op  output  2;  pc_src  output  2  datapath mux and ALU controls.
REQ-010 ext_zero  output  1  immediate extender mode: 0 = sign-extend imm[15] into bits [31:16], 1 = zero-extend.
REQ-011 fault  output  1  sticky: illegal opcode or memory timeout.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, IMM_EX, IMM_WB, JUMP_EX, FAULT.
REQ-013 Opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 001100 andi, 001101 ori, 000010 j; all others illegal.
REQ-014 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_write pulse only in the cycle mem_ready=1, then -> DECODE; otherwise stay.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target); one cycle; dispatch by op: lw/sw -> MEMADR, R -> RTYPE_EX, beq -> BEQ_EX, addi/andi/ori -> IMM_EX, j -> JUMP_EX, illegal -> FAULT.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
REQ-018 MEMWR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
REQ-019 RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10; -> RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-020 BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; -> FETCH.
REQ-021 IMM_EX: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for andi/ori; -> IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-022 JUMP_EX: pc_write=1, pc_src=10; -> FETCH.
REQ-023 ext_zero=1 exactly in MEMADR/IMM_EX/IMM_WB when op is andi/ori; 0 elsewhere.
REQ-024 Wait counter clears on entering FETCH/MEMRD/MEMWR, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> FAULT with no ir_write/pc_write/reg_write issued.
REQ-025 mem_ready ignored outside FETCH/MEMRD/MEMWR.
REQ-026 FAULT: all strobes 0, fault=1, held until reset.
REQ-027 All outputs Moore (state-decoded) except the mem_ready-qualified ir_write/pc_write in FETCH.

Reset
REQ-028 reset=1 at any edge, including mid-access -> FETCH, counter=0, fault=0; during reset all strobes 0, mem_req=0.

Configuration
REQ-029 ZERO_EXT_EN defined: andi/ori legal per REQ-021/023; undefined: ext_zero tied 0, andi/ori decode as illegal -> FAULT.

Structure
REQ-030 Shared package mips_ctrl_pkg: state enum, opcode constants, alu_op and pc_src encodings.
REQ-031 One sub-module mem_wait_timer: counter + timeout flag, parameterised by MEM_TIMEOUT.

Verification
REQ-032 lw, mem_ready high 1st cycle: FETCH,DECODE,MEMADR,MEMRD,MEMWB -> 5 cycles, one reg_write with mem_to_reg=1.
REQ-033 sw with mem_ready delayed 3 cycles in MEMWR: mem_we held 4 cycles, no reg_write, returns to FETCH.
REQ-034 ori (op=001101), ZERO_EXT_EN defined: ext_zero=1 in IMM_EX/IMM_WB, alu_op=11; undefined: fault=1 after DECODE.
REQ-035 mem_ready held 0 in FETCH, MEM_TIMEOUT=16: fault asserts after 16 cycles, ir_write never pulses.
REQ-036 Illegal op=111111: FAULT after DECODE; reset asserted mid-MEMRD: next cycle FETCH, fault=0, mem_req=0 while reset.
REQ-037 beq then j: pc_write_cond with pc_src=01 in BEQ_EX; pc_write with pc_src=10 in JUMP_EX; each 3 cycles.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM states,
// opcode constants, ALU-op / PC-source / ALU-B-source encodings.
// Optional feature macro: ZERO_EXT_EN (andi/ori support, zero-extended immediates).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_RTYPE_EX,
        ST_RTYPE_WB,
        ST_BEQ_EX,
        ST_IMM_EX,
        ST_IMM_WB,
        ST_JUMP_EX,
        ST_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // andi/ori are the only opcodes that want a zero-extended immediate
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// master: controller (takes opcode + memory ready, drives all controls)
// slave : datapath side (drives opcode + memory ready, takes controls)
interface multicycle_control_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_zero;
    logic       fault;

    modport master (
        input  op, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, ext_zero, fault
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_op, pc_src, ext_zero, fault
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for mem_ready and flags
// the cycle in which the MEM_TIMEOUT-th consecutive wait cycle occurs.
// Ports: clk, reset (sync, active-high), clr (restart count), inc (waiting
// cycle without mem_ready), timeout_c (combinational timeout flag).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic timeout_c
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    // count saturates at LAST; the FSM leaves the wait state on timeout anyway
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign timeout_c = inc && (count == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/execute states, sticky FAULT).
// Ports: clk, reset (sync, active-high), bus (multicycle_control_if.master:
// op/mem_ready in, all datapath controls and fault out).
// Optional feature macro: ZERO_EXT_EN -- enables andi/ori with zero-extended
// immediates; without it those opcodes are illegal and ext_zero stays 0.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
`ifdef ZERO_EXT_EN
    localparam bit ZEXT_EN = 1'b1;
`else
    localparam bit ZEXT_EN = 1'b0;
`endif

    state_t state;
    state_t state_next;
    logic   waiting;
    logic   timer_clr;
    logic   timer_inc;
    logic   timeout_c;
    logic   zext_op_c;

    assign zext_op_c = ZEXT_EN && is_logic_imm(bus.op);

    // mem_ready only matters in the three memory-access states
    assign waiting   = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
    assign timer_inc = waiting && !bus.mem_ready;
    assign timer_clr = (state_next != state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr),
        .inc       (timer_inc),
        .timeout_c (timeout_c)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (bus.mem_ready)  state_next = ST_DECODE;
                else if (timeout_c) state_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:     state_next = ST_MEMADR;
                    OP_RTYPE:         state_next = ST_RTYPE_EX;
                    OP_BEQ:           state_next = ST_BEQ_EX;
                    OP_ADDI:          state_next = ST_IMM_EX;
                    OP_ANDI, OP_ORI:  state_next = zext_op_c ? ST_IMM_EX : ST_FAULT;
                    OP_J:             state_next = ST_JUMP_EX;
                    default:          state_next = ST_FAULT;
                endcase
            end
            ST_MEMADR:   state_next = (bus.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (bus.mem_ready)  state_next = ST_MEMWB;
                else if (timeout_c) state_next = ST_FAULT;
            end
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWR: begin
                if (bus.mem_ready)  state_next = ST_FETCH;
                else if (timeout_c) state_next = ST_FAULT;
            end
            ST_RTYPE_EX: state_next = ST_RTYPE_WB;
            ST_RTYPE_WB: state_next = ST_FETCH;
            ST_BEQ_EX:   state_next = ST_FETCH;
            ST_IMM_EX:   state_next = ST_IMM_WB;
            ST_IMM_WB:   state_next = ST_FETCH;
            ST_JUMP_EX:  state_next = ST_FETCH;
            ST_FAULT:    state_next = ST_FAULT;
            default:     state_next = ST_FAULT;
        endcase
    end

    // state-decoded outputs; reset forces every control low
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_src        = PC_SRC_ALU;
        bus.ext_zero      = 1'b0;
        bus.fault         = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    // IR and PC load only in the cycle memory returns the word
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                ST_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SHL2;
                end
                ST_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.ext_zero  = zext_op_c;
                end
                ST_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                ST_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.iord    = 1'b1;
                end
                ST_RTYPE_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                ST_RTYPE_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                ST_BEQ_EX: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = PC_SRC_ALUOUT;
                end
                ST_IMM_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = is_logic_imm(bus.op) ? ALU_LOGIC : ALU_ADD;
                    bus.ext_zero  = zext_op_c;
                end
                ST_IMM_WB: begin
                    bus.reg_write = 1'b1;
                    bus.ext_zero  = zext_op_c;
                end
                ST_JUMP_EX: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_SRC_JUMP;
                end
                ST_FAULT: begin
                    bus.fault = 1'b1;
                end
                default: begin
                    bus.fault = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: builds the expected per-cycle control trace
// of each instruction from its phase list, drives op/mem_ready/reset along
// that trace and compares the DUT controls every cycle.
// Macro ZERO_EXT_EN selects whether andi/ori are expected to be legal.
module tb_multicycle_control;
    localparam int unsigned MEM_TIMEOUT = 16;
`ifdef ZERO_EXT_EN
    localparam bit ZX = 1'b1;
`else
    localparam bit ZX = 1'b0;
`endif

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JMP  = 6'b000010;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       fault;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        bit         rdy;
        bit         rst;
    } step_t;

    logic  clk = 1'b0;
    logic  reset;
    step_t plan[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic bit legal(input logic [5:0] o);
        if (o == ANDI || o == ORI) return ZX;
        return (o == RT) || (o == LW) || (o == SW) || (o == BEQ) ||
               (o == ADDI) || (o == JMP);
    endfunction

    function automatic void push(input string n, input logic [5:0] o, input bit rdy, input bit rst);
        step_t s;
        s.name = n;
        s.op   = o;
        s.rdy  = rdy;
        s.rst  = rst;
        plan.push_back(s);
    endfunction

    // one cycle in a state that must ignore mem_ready: drive it randomly
    function automatic void push_any(input string n, input logic [5:0] o);
        push(n, o, 1'($urandom_range(0, 1)), 1'b0);
    endfunction

    function automatic void add_fault(input logic [5:0] o);
        for (int i = 0; i < 3; i++) push_any("FAULT", o);
        push("RESET", o, 1'($urandom_range(0, 1)), 1'b1);
    endfunction

    // memory access with 'lat' not-ready cycles; returns 1 if it times out
    function automatic bit add_wait(input string n, input logic [5:0] o, input int lat);
        int waits;
        waits = (lat >= int'(MEM_TIMEOUT)) ? int'(MEM_TIMEOUT) : lat;
        for (int i = 0; i < waits; i++) push(n, o, 1'b0, 1'b0);
        if (lat >= int'(MEM_TIMEOUT)) begin
            add_fault(o);
            return 1'b1;
        end
        push(n, o, 1'b1, 1'b0);
        return 1'b0;
    endfunction

    // full instruction: fetch latency lf, data latency ld
    function automatic void add_instr(input logic [5:0] o, input int lf, input int ld);
        if (add_wait("FETCH", o, lf)) return;
        push_any("DECODE", o);
        if (!legal(o)) begin
            add_fault(o);
            return;
        end
        if (o == LW) begin
            push_any("MEMADR", o);
            if (add_wait("MEMRD", o, ld)) return;
            push_any("MEMWB", o);
        end else if (o == SW) begin
            push_any("MEMADR", o);
            void'(add_wait("MEMWR", o, ld));
        end else if (o == RT) begin
            push_any("RTYPE_EX", o);
            push_any("RTYPE_WB", o);
        end else if (o == BEQ) begin
            push_any("BEQ_EX", o);
        end else if (o == JMP) begin
            push_any("JUMP_EX", o);
        end else begin
            push_any("IMM_EX", o);
            push_any("IMM_WB", o);
        end
    endfunction

    // expected value v and care mask c for one cycle of a phase
    function automatic void exp_ctl(input string n, input logic [5:0] o, input bit rdy,
                                    input bit rst, output ctl_t v, output ctl_t c);
        bit zx;
        zx = ZX && (o == ANDI || o == ORI);
        v = '0;
        c = '0;
        c.mem_req = 1'b1; c.mem_we = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.pc_write_cond = 1'b1; c.reg_write = 1'b1; c.ext_zero = 1'b1; c.fault = 1'b1;
        if (rst) return;
        case (n)
            "FETCH": begin
                v.mem_req = 1'b1; v.ir_write = rdy; v.pc_write = rdy; v.alu_src_b = 2'b01;
                c.iord = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11;
                c.alu_op = 2'b11; c.pc_src = 2'b11;
            end
            "DECODE": begin
                v.alu_src_b = 2'b11;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 2'b11;
            end
            "MEMADR": begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.ext_zero = zx;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 2'b11;
            end
            "MEMRD": begin
                v.mem_req = 1'b1; v.iord = 1'b1; c.iord = 1'b1;
            end
            "MEMWB": begin
                v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
                c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
            end
            "MEMWR": begin
                v.mem_req = 1'b1; v.mem_we = 1'b1; v.iord = 1'b1; c.iord = 1'b1;
            end
            "RTYPE_EX": begin
                v.alu_src_a = 1'b1; v.alu_op = 2'b10;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 2'b11;
            end
            "RTYPE_WB": begin
                v.reg_write = 1'b1; v.reg_dst = 1'b1;
                c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
            end
            "BEQ_EX": begin
                v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_write_cond = 1'b1; v.pc_src = 2'b01;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 2'b11; c.pc_src = 2'b11;
            end
            "IMM_EX": begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.ext_zero = zx;
                v.alu_op = (o == ANDI || o == ORI) ? 2'b11 : 2'b00;
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 2'b11;
            end
            "IMM_WB": begin
                v.reg_write = 1'b1; v.ext_zero = zx;
                c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
            end
            "JUMP_EX": begin
                v.pc_write = 1'b1; v.pc_src = 2'b10; c.pc_src = 2'b11;
            end
            "FAULT": v.fault = 1'b1;
            default: ;
        endcase
    endfunction

    // play the plan one cycle per step: drive after the edge, check mid-cycle
    task automatic run_plan();
        step_t       s;
        ctl_t        ev;
        ctl_t        ec;
        logic [17:0] obs;
        logic [17:0] want;
        int          idx = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            reset         = s.rst;
            bus.op        = s.op;
            bus.mem_ready = s.rdy;
            #4;
            exp_ctl(s.name, s.op, s.rdy, s.rst, ev, ec);
            obs  = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                    bus.pc_write_cond, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                    bus.ext_zero, bus.fault} & ec;
            want = ev & ec;
            checks++;
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s step=%0d op=%b rdy=%0b rst=%0b observed=%h expected=%h",
                       s.name, idx, s.op, s.rdy, s.rst, obs, want);
            end
            idx++;
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] o;
        int         lf;
        int         ld;
        ops[0] = RT;  ops[1] = LW;   ops[2] = SW;   ops[3] = BEQ;
        ops[4] = ADDI; ops[5] = ANDI; ops[6] = ORI; ops[7] = JMP;

        reset         = 1'b1;
        bus.op        = 6'b0;
        bus.mem_ready = 1'b0;

        push("RESET", RT, 1'b1, 1'b1);
        push("RESET", RT, 1'b0, 1'b1);
        add_instr(LW, 0, 0);          // five-cycle load, single writeback
        add_instr(SW, 0, 3);          // store held four cycles
        add_instr(ORI, 1, 0);         // zero-extended or faults without the feature
        add_instr(ANDI, 0, 0);
        add_instr(ADDI, 2, 0);
        add_instr(RT, 0, 0);
        add_instr(BEQ, 0, 0);
        add_instr(JMP, 0, 0);
        add_instr(LW, 15, 15);        // one short of timeout in both accesses
        add_instr(SW, 0, 16);         // data-side timeout
        add_instr(RT, 16, 0);         // fetch timeout, no ir_write
        add_instr(6'b111111, 0, 0);   // illegal opcode

        // reset in the middle of a load read, then a clean load
        push("FETCH", LW, 1'b1, 1'b0);
        push_any("DECODE", LW);
        push_any("MEMADR", LW);
        push("MEMRD", LW, 1'b0, 1'b0);
        push("MEMRD", LW, 1'b0, 1'b0);
        push("RESET", LW, 1'b0, 1'b1);
        add_instr(LW, 0, 1);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            else                           o = ops[$urandom_range(0, 7)];
            lf = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            ld = ($urandom_range(0, 11) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
            add_instr(o, lf, ld);
        end

        run_plan();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
